// File: rtl/store_buffer.sv
// store_buffer: FIFO of retired stores between the core data port and a
// variable-latency data memory. It forwards buffered data to loads and stalls
// the core only when the buffer is full or a load misses.
// Optional feature macro: STORE_BUF_COALESCE_EN (merge a store into the
// youngest buffered entry of the same word instead of pushing a new one).
module store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_wr,
    input  logic                      cpu_rd,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_stall,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ack,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TAG_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        RDONE = 2'd3
    } state_t;

    state_t              state_q, state_n;
    logic [TAG_W-1:0]    tag_q  [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [PTR_W-1:0]    head_q, tail_q;
    logic [CNT_W-1:0]    count_q;
    logic [DATA_W-1:0]   load_ret_q, load_ret_n;
    logic                mem_req_q, mem_req_n;
    logic                mem_we_q, mem_we_n;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_n;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_n;

    logic [TAG_W-1:0]    cpu_tag;
    logic                fwd_hit;
    logic [DATA_W-1:0]   fwd_data;
    logic                coal_hit;
    logic                coal_head;
    logic [PTR_W-1:0]    wr_idx;
    logic                pop;
    logic                push;
    logic                accept;
    logic                load_miss;

    assign cpu_tag   = cpu_addr[ADDR_W-1:2];
    assign pop       = (state_q == WR) && mem_ack;
    assign accept    = cpu_wr && (coal_hit || (count_q < CNT_W'(DEPTH)) || pop);
    assign push      = accept && !coal_hit;
    assign load_miss = cpu_rd && !fwd_hit;

    // Youngest valid entry matching the load word address; a popping head still counts.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && (tag_q[head_q + PTR_W'(i)] == cpu_tag)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[head_q + PTR_W'(i)];
            end
        end
    end

`ifdef STORE_BUF_COALESCE_EN
    logic             coal_match;
    logic [PTR_W-1:0] coal_idx;

    // Youngest mergeable entry for a store; the head is locked while its write is in flight.
    always_comb begin
        coal_match = 1'b0;
        coal_idx   = tail_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && (tag_q[head_q + PTR_W'(i)] == cpu_tag) &&
                !((i == 0) && (state_q == WR))) begin
                coal_match = 1'b1;
                coal_idx   = head_q + PTR_W'(i);
            end
        end
    end

    assign coal_hit  = cpu_wr && coal_match;
    assign wr_idx    = coal_hit ? coal_idx : tail_q;
    assign coal_head = coal_hit && (coal_idx == head_q);
`else
    assign coal_hit  = 1'b0;
    assign wr_idx    = tail_q;
    assign coal_head = 1'b0;
`endif

    // Next-state and memory-port next values.
    always_comb begin
        state_n     = state_q;
        mem_req_n   = mem_req_q;
        mem_we_n    = mem_we_q;
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;
        load_ret_n  = load_ret_q;
        case (state_q)
            IDLE: begin
                if (load_miss) begin
                    state_n    = RD;
                    mem_req_n  = 1'b1;
                    mem_we_n   = 1'b0;
                    mem_addr_n = cpu_addr;
                end else if (count_q != '0) begin
                    state_n     = WR;
                    mem_req_n   = 1'b1;
                    mem_we_n    = 1'b1;
                    mem_addr_n  = {tag_q[head_q], 2'b00};
                    // A store merging into the head this cycle must reach memory too.
                    mem_wdata_n = coal_head ? cpu_wdata : data_q[head_q];
                end
            end
            WR: begin
                if (mem_ack) begin
                    state_n   = IDLE;
                    mem_req_n = 1'b0;
                end
            end
            RD: begin
                if (mem_ack) begin
                    state_n    = RDONE;
                    mem_req_n  = 1'b0;
                    load_ret_n = mem_rdata;
                end
            end
            RDONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, pointers, occupancy and registered memory port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            load_ret_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_n;
            head_q      <= head_q + PTR_W'(pop);
            tail_q      <= tail_q + PTR_W'(push);
            count_q     <= count_q + CNT_W'(push) - CNT_W'(pop);
            load_ret_q  <= load_ret_n;
            mem_req_q   <= mem_req_n;
            mem_we_q    <= mem_we_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
        end
    end

    // Entry storage: write on push at tail or merge in place.
    always_ff @(posedge clk) begin
        if (rst && accept) begin
            tag_q[wr_idx]  <= cpu_tag;
            data_q[wr_idx] <= cpu_wdata;
        end
    end

    assign cpu_stall = (cpu_wr && !accept) || (load_miss && (state_q != RDONE));
    assign cpu_rdata = (state_q == RDONE) ? load_ret_q :
                       (cpu_rd && fwd_hit) ? fwd_data : '0;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and random stimulus for store_buffer, checked
// against a queue-based store buffer model and an associative-array memory.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [2:0]  count;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    ent_t        sq[$];
    logic [31:0] mem_arr [logic [31:0]];
    logic [32:0] txn_log[$];
    logic [32:0] exp_log[$];

    int   tests;
    int   fails;
    bit   hold;
    bit   lat_rand;
    int   lat;
    int   req_cnt;
    logic stall_s;
    logic [31:0] rdata_s;
    bit   acc_s;

    function automatic logic [31:0] mem_val(logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: memory responds, outputs sampled, model advanced, count checked.
    task automatic cycle();
        bit   wr_pop;
        bit   inflight;
        int   midx;
        ent_t e;
        wr_pop   = 1'b0;
        midx     = -1;
        mem_ack  = 1'b0;
        inflight = (mem_req === 1'b1) && (mem_we === 1'b1);
        if (mem_req === 1'b1) begin
            req_cnt++;
            if (!hold && req_cnt >= lat) begin
                mem_ack = 1'b1;
                req_cnt = 0;
                txn_log.push_back({mem_we, mem_addr});
                if (mem_we) begin
                    tests++;
                    assert (sq.size() > 0) else begin
                        fails++;
                        $error("FAIL wr_unexpected: write %h with empty model", mem_addr);
                    end
                    if (sq.size() > 0) begin
                        chk("wr_addr", 64'(mem_addr), 64'(sq[0].addr));
                        chk("wr_data", 64'(mem_wdata), 64'(sq[0].data));
                        mem_arr[sq[0].addr] = sq[0].data;
                        wr_pop = 1'b1;
                    end
                end else begin
                    mem_rdata = mem_val(mem_addr);
                end
                if (lat_rand) lat = $urandom_range(1, 4);
            end
        end
        #1;
        stall_s = cpu_stall;
        rdata_s = cpu_rdata;
        acc_s   = 1'b0;
        if (cpu_wr) begin
`ifdef STORE_BUF_COALESCE_EN
            for (int i = 0; i < sq.size(); i++)
                if (sq[i].addr == (cpu_addr & 32'hFFFF_FFFC) && !(i == 0 && inflight)) midx = i;
`endif
            acc_s = (midx >= 0) || (sq.size() < DEPTH) || wr_pop;
            chk("wr_stall", 64'(stall_s), 64'(!acc_s));
        end
        if (wr_pop) void'(sq.pop_front());
        if (acc_s) begin
            if (midx >= 0) begin
                if (wr_pop) midx = midx - 1;
                e = sq[midx];
                e.data = cpu_wdata;
                sq[midx] = e;
            end else begin
                e.addr = cpu_addr & 32'hFFFF_FFFC;
                e.data = cpu_wdata;
                sq.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("count", 64'(count), 64'(sq.size()));
    endtask

    task automatic do_store(logic [31:0] a, logic [31:0] d);
        int n;
        n = 0;
        cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = d;
        do begin cycle(); n++; end while (!acc_s && n < 50);
        tests++;
        assert (acc_s) else begin
            fails++;
            $error("FAIL store_timeout: addr %h not accepted after %0d cycles", a, n);
        end
        cpu_wr = 1'b0;
    endtask

    task automatic do_load(logic [31:0] a, output int ncyc);
        int          midx;
        logic [31:0] exp;
        midx = -1;
        for (int i = 0; i < sq.size(); i++) if (sq[i].addr == a) midx = i;
        exp = (midx >= 0) ? sq[midx].data : mem_val(a);
        cpu_rd = 1'b1; cpu_addr = a;
        ncyc = 0;
        do begin cycle(); ncyc++; end while (stall_s && ncyc < 60);
        chk("ld_stall_end", 64'(stall_s), 64'd0);
        chk("ld_data", 64'(rdata_s), 64'(exp));
        if (midx >= 0) begin
            chk("ld_hit_cycles", 64'(ncyc), 64'd1);
        end else begin
            tests++;
            assert (ncyc >= 3) else begin
                fails++;
                $error("FAIL ld_miss_latency: got %0d cycles expected >= 3", ncyc);
            end
        end
        cpu_rd = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin cycle(); n++; end while ((sq.size() != 0 || mem_req !== 1'b0) && n < 100);
        tests++;
        assert (sq.size() == 0 && mem_req === 1'b0) else begin
            fails++;
            $error("FAIL drain_timeout: %0d entries left, mem_req %b", sq.size(), mem_req);
        end
    endtask

    task automatic check_log(string tag);
        chk({tag, "_len"}, 64'(txn_log.size()), 64'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < txn_log.size(); i++)
            chk(tag, 64'(txn_log[i]), 64'(exp_log[i]));
        txn_log.delete();
        exp_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int          ncyc;
    int          n;
    int          op;
    logic [31:0] ra;
    logic [31:0] rd;

    initial begin
        tests = 0; fails = 0;
        hold = 1'b0; lat_rand = 1'b0; lat = 1; req_cnt = 0;
        rst = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

        // Power-on reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_stall", 64'(cpu_stall), 64'd0);
        chk("rst_rdata", 64'(cpu_rdata), 64'd0);
        @(negedge clk);

        // Reset while a write is outstanding; a late ack must be ignored.
        hold = 1'b1;
        do_store(32'h10, 32'hDEAD_0010);
        cycle();
        chk("pre_rst_req", 64'(mem_req), 64'd1);
        chk("pre_rst_we", 64'(mem_we), 64'd1);
        rst = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        sq.delete(); txn_log.delete(); req_cnt = 0;
        #1;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_req", 64'(mem_req), 64'd0);
        chk("mid_rst_we", 64'(mem_we), 64'd0);
        chk("mid_rst_addr", 64'(mem_addr), 64'd0);
        chk("mid_rst_wdata", 64'(mem_wdata), 64'd0);
        mem_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_count", 64'(count), 64'd0);
        chk("late_ack_req", 64'(mem_req), 64'd0);
        hold = 1'b0;
        cycle();
        chk("late_ack_idle_req", 64'(mem_req), 64'd0);

        // Fill to DEPTH, fifth store stalls until the head write completes.
        hold = 1'b1; lat = 1;
        do_store(32'h10, 32'h1111_0010);
        do_store(32'h14, 32'h1111_0014);
        do_store(32'h18, 32'h1111_0018);
        do_store(32'h1C, 32'h1111_001C);
        chk("full_count", 64'(count), 64'd4);
        cpu_wr = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1111_0020;
        repeat (3) begin cycle(); chk("full_stall", 64'(stall_s), 64'd1); end
        hold = 1'b0;
        n = 0;
        do begin cycle(); n++; end while (!acc_s && n < 20);
        tests++;
        assert (acc_s) else begin fails++; $error("FAIL full_accept: not accepted after %0d", n); end
        cpu_wr = 1'b0;
        chk("full_swap_count", 64'(count), 64'd4);
        drain();
        exp_log.push_back({1'b1, 32'h10}); exp_log.push_back({1'b1, 32'h14});
        exp_log.push_back({1'b1, 32'h18}); exp_log.push_back({1'b1, 32'h1C});
        exp_log.push_back({1'b1, 32'h20});
        check_log("full_order");

        // Two stores to one word, then a forwarded load with memory stalled.
        hold = 1'b1;
        do_store(32'h40, 32'hAAAA_0001);
        do_store(32'h40, 32'hBBBB_0002);
`ifdef STORE_BUF_COALESCE_EN
        chk("same_word_count", 64'(count), 64'd1);
`else
        chk("same_word_count", 64'(count), 64'd2);
`endif
        do_load(32'h40, ncyc);
        chk("fwd_data", 64'(rdata_s), 64'hBBBB_0002);
        hold = 1'b0;
        drain();
        chk("fwd_mem", 64'(mem_val(32'h40)), 64'hBBBB_0002);
        txn_log.delete();

        // Load miss with an empty buffer and a two-cycle memory.
        mem_arr[32'h80] = 32'h1234_5678;
        lat = 2;
        do_load(32'h80, ncyc);
        chk("miss_data", 64'(rdata_s), 64'h1234_5678);
        chk("miss_cycles", 64'(ncyc), 64'd4);
        exp_log.push_back({1'b0, 32'h80});
        check_log("miss_txn");

        // Load miss behind a pending write takes priority over queued stores.
        hold = 1'b1; lat = 1;
        do_store(32'h10, 32'h2222_0010);
        do_store(32'h14, 32'h2222_0014);
        do_store(32'h18, 32'h2222_0018);
        hold = 1'b0;
        do_load(32'h100, ncyc);
        drain();
        exp_log.push_back({1'b1, 32'h10}); exp_log.push_back({1'b0, 32'h100});
        exp_log.push_back({1'b1, 32'h14}); exp_log.push_back({1'b1, 32'h18});
        check_log("prio_order");

        // Ten stores through the FIFO, pointers wrap.
        for (int k = 0; k < 10; k++) begin
            do_store(32'h300 + 32'(4 * k), 32'hC0DE_0000 + 32'(k));
            exp_log.push_back({1'b1, 32'h300 + 32'(4 * k)});
        end
        drain();
        check_log("wrap_order");
        for (int k = 0; k < 10; k++)
            chk("wrap_mem", 64'(mem_val(32'h300 + 32'(4 * k))), 64'(32'hC0DE_0000 + 32'(k)));

        // Random mix of stores, loads and idle cycles over a few words.
        lat_rand = 1'b1;
        for (int k = 0; k < 200; k++) begin
            op = int'($urandom_range(0, 9));
            ra = 32'h200 + 32'(4 * $urandom_range(0, 5));
            rd = $urandom();
            if (op < 5) do_store(ra, rd);
            else if (op < 8) do_load(ra, ncyc);
            else cycle();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
